// File: rtl/tetris_move_scheduler_if.sv
// Board-datapath bus between the move scheduler (master) and the board canvas (slave):
// collision query, lock/clear handshakes and the committed piece position.
interface tetris_move_scheduler_if;
  logic        query_valid;
  logic [4:0]  query_x;
  logic [4:0]  query_y;
  logic        query_hit;
  logic        lock_valid;
  logic        clear_req;
  logic        clear_done;
  logic [2:0]  lines_in;
  logic [4:0]  piece_x;
  logic [4:0]  piece_y;
  logic [15:0] piece_shape;

  modport master (
    output query_valid, query_x, query_y, lock_valid, clear_req,
           piece_x, piece_y, piece_shape,
    input  query_hit, clear_done, lines_in
  );

  modport slave (
    input  query_valid, query_x, query_y, lock_valid, clear_req,
           piece_x, piece_y, piece_shape,
    output query_hit, clear_done, lines_in
  );
endinterface

// File: rtl/tetris_move_scheduler.sv
// Falling-piece sequencer: arbitrates gravity/left/right requests onto one collision-query
// port, commits accepted moves, locks landed pieces, requests row clears and respawns.
module tetris_move_scheduler #(
  parameter int COLS    = 10,
  parameter int ROWS    = 16,
  parameter int X_SPAWN = 3
) (
  input  logic                           clkSelect,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           tick,
  input  logic                           left_req,
  input  logic                           right_req,
  input  logic [15:0]                    shape_in,
  tetris_move_scheduler_if.master        board,
  output logic                           piece_active,
  output logic                           game_over,
  output logic [15:0]                    lines_total
);

  if (X_SPAWN < 0 || X_SPAWN + 4 > COLS || ROWS > 31) begin : g_bad_params
    $error("tetris_move_scheduler: spawn column or playfield size out of range");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_SPAWN, S_SPAWN_CHK, S_WAIT, S_QUERY, S_RESOLVE, S_LOCK, S_CLEAR, S_OVER
  } state_t;

  typedef enum logic [1:0] {OP_TICK, OP_LEFT, OP_RIGHT} op_t;

  state_t      r_state;
  op_t         r_op;
  logic        r_chk_phase;
  logic        r_pend_t, r_pend_l, r_pend_r;
  logic [4:0]  r_x, r_y, r_qx, r_qy;
  logic [15:0] r_shape;
  logic [15:0] r_lines;
  logic        r_qvalid, r_lock, r_clear;

  logic        w_accept;
  logic        w_set_t, w_set_l, w_set_r;
  logic        w_svc_t, w_svc_l, w_svc_r;
  logic [16:0] w_lines_sum;

  always_comb begin
    w_accept    = (r_state != S_IDLE) && (r_state != S_OVER);
    w_set_t     = w_accept & tick;
    // Simultaneous left and right cancel each other out.
    w_set_l     = w_accept & left_req & ~right_req;
    w_set_r     = w_accept & right_req & ~left_req;
    w_svc_t     = (r_state == S_WAIT) & r_pend_t;
    w_svc_l     = (r_state == S_WAIT) & ~r_pend_t & r_pend_l;
    w_svc_r     = (r_state == S_WAIT) & ~r_pend_t & ~r_pend_l & r_pend_r;
    w_lines_sum = {1'b0, r_lines} + {14'd0, board.lines_in};
  end

  always_ff @(posedge clkSelect) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_TICK;
      r_chk_phase <= 1'b0;
      r_pend_t    <= 1'b0;
      r_pend_l    <= 1'b0;
      r_pend_r    <= 1'b0;
      r_x         <= 5'(X_SPAWN);
      r_y         <= '0;
      r_qx        <= 5'(X_SPAWN);
      r_qy        <= '0;
      r_shape     <= '0;
      r_lines     <= '0;
      r_qvalid    <= 1'b0;
      r_lock      <= 1'b0;
      r_clear     <= 1'b0;
    end else begin
      r_qvalid <= 1'b0;
      r_lock   <= 1'b0;
      r_clear  <= 1'b0;
      r_pend_t <= (r_pend_t & ~w_svc_t) | w_set_t;
      r_pend_l <= (r_pend_l & ~w_svc_l) | w_set_l;
      r_pend_r <= (r_pend_r & ~w_svc_r) | w_set_r;

      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_SPAWN;
        end
        S_SPAWN: begin
          r_shape     <= shape_in;
          r_x         <= 5'(X_SPAWN);
          r_y         <= '0;
          r_qx        <= 5'(X_SPAWN);
          r_qy        <= '0;
          r_qvalid    <= 1'b1;
          r_chk_phase <= 1'b0;
          r_state     <= S_SPAWN_CHK;
        end
        S_SPAWN_CHK: begin
          // First cycle carries the query, second cycle sees the board's answer.
          if (!r_chk_phase) r_chk_phase <= 1'b1;
          else              r_state     <= board.query_hit ? S_OVER : S_WAIT;
        end
        S_WAIT: begin
          if (w_svc_t) begin
            r_op     <= OP_TICK;
            r_qx     <= r_x;
            r_qy     <= r_y + 5'd1;
            r_qvalid <= 1'b1;
            r_state  <= S_QUERY;
          end else if (w_svc_l) begin
            r_op     <= OP_LEFT;
            r_qx     <= r_x - 5'd1;
            r_qy     <= r_y;
            r_qvalid <= 1'b1;
            r_state  <= S_QUERY;
          end else if (w_svc_r) begin
            r_op     <= OP_RIGHT;
            r_qx     <= r_x + 5'd1;
            r_qy     <= r_y;
            r_qvalid <= 1'b1;
            r_state  <= S_QUERY;
          end
        end
        S_QUERY: begin
          r_state <= S_RESOLVE;
        end
        S_RESOLVE: begin
          if (!board.query_hit) begin
            r_x     <= r_qx;
            r_y     <= r_qy;
            r_state <= S_WAIT;
          end else if (r_op == OP_TICK) begin
            r_lock  <= 1'b1;
            r_state <= S_LOCK;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_LOCK: begin
          r_pend_l <= 1'b0;
          r_pend_r <= 1'b0;
          r_clear  <= 1'b1;
          r_state  <= S_CLEAR;
        end
        S_CLEAR: begin
          if (board.clear_done) begin
            r_lines <= w_lines_sum[16] ? 16'hFFFF : w_lines_sum[15:0];
            r_state <= S_SPAWN;
          end
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign board.query_valid = r_qvalid;
  assign board.query_x     = r_qx;
  assign board.query_y     = r_qy;
  assign board.lock_valid  = r_lock;
  assign board.clear_req   = r_clear;
  assign board.piece_x     = r_x;
  assign board.piece_y     = r_y;
  assign board.piece_shape = r_shape;
  assign piece_active      = (r_state == S_WAIT) || (r_state == S_QUERY) || (r_state == S_RESOLVE);
  assign game_over         = (r_state == S_OVER);
  assign lines_total       = r_lines;

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Directed bench for tetris_move_scheduler: expected collision queries are queued as stimulus
// is driven and matched against the query port; state/position checks are inline.
module tb_tetris_move_scheduler;

  logic        clk = 1'b0;
  logic        reset, start, tick, left_req, right_req;
  logic [15:0] shape_in;
  logic        piece_active, game_over;
  logic [15:0] lines_total;
  logic        hit_cfg;
  logic        lock_seen;

  int n_vec = 0;
  int n_err = 0;
  int n_q   = 0;
  int q_mark;

  typedef struct packed {logic [4:0] x; logic [4:0] y;} qexp_t;
  qexp_t exp_q[$];

  tetris_move_scheduler_if bif();

  tetris_move_scheduler #(.COLS(10), .ROWS(16), .X_SPAWN(3)) dut (
    .clkSelect   (clk),
    .reset       (reset),
    .start       (start),
    .tick        (tick),
    .left_req    (left_req),
    .right_req   (right_req),
    .shape_in    (shape_in),
    .board       (bif.master),
    .piece_active(piece_active),
    .game_over   (game_over),
    .lines_total (lines_total)
  );

  always #5 clk = ~clk;

  // Board stand-in: answers every query one cycle later with the configured hit value.
  always @(posedge clk) bif.query_hit <= bif.query_valid & hit_cfg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] x, input logic [4:0] y);
    qexp_t e;
    e.x = x;
    e.y = y;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bif.lock_valid === 1'b1) lock_seen = 1'b1;
    if (bif.query_valid === 1'b1) begin
      n_q++;
      if (exp_q.size() == 0) begin
        chk("unexpected_query", 32'(bif.query_valid), 32'd0);
      end else begin
        qexp_t e;
        e = exp_q.pop_front();
        chk("query_x", 32'(bif.query_x), 32'(e.x));
        chk("query_y", 32'(bif.query_y), 32'(e.y));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; left_req = 1'b0; right_req = 1'b0;
    shape_in = 16'h0660; hit_cfg = 1'b0; lock_seen = 1'b0;
    bif.clear_done = 1'b0; bif.lines_in = 3'd0;
    cyc(2);
    chk("rst_x", 32'(bif.piece_x), 32'd3);
    chk("rst_y", 32'(bif.piece_y), 32'd0);
    chk("rst_shape", 32'(bif.piece_shape), 32'd0);
    chk("rst_lines", 32'(lines_total), 32'd0);
    chk("rst_active", 32'(piece_active), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);
    chk("rst_qvalid", 32'(bif.query_valid), 32'd0);
    chk("rst_pulses", 32'({bif.lock_valid, bif.clear_req}), 32'd0);

    // 1: start and spawn at (3,0)
    reset = 1'b0; start = 1'b1; push(5'd3, 5'd0);
    cyc(4);
    start = 1'b0;
    chk("spawn_active", 32'(piece_active), 32'd1);
    chk("spawn_x", 32'(bif.piece_x), 32'd3);
    chk("spawn_y", 32'(bif.piece_y), 32'd0);
    chk("spawn_shape", 32'(bif.piece_shape), 32'h0660);

    // 2: gravity tick, latency of query and commit
    push(5'd3, 5'd1);
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("tick_q_early", 32'(bif.query_valid), 32'd0);
    cyc(1);
    chk("tick_q_valid", 32'(bif.query_valid), 32'd1);
    chk("tick_y_hold", 32'(bif.piece_y), 32'd0);
    cyc(2);
    chk("tick_y_commit", 32'(bif.piece_y), 32'd1);

    // 3: tick and left together, tick first
    q_mark = n_q;
    push(5'd3, 5'd2); push(5'd2, 5'd2);
    tick = 1'b1; left_req = 1'b1; cyc(1); tick = 1'b0; left_req = 1'b0;
    cyc(8);
    chk("tl_x", 32'(bif.piece_x), 32'd2);
    chk("tl_y", 32'(bif.piece_y), 32'd2);
    chk("tl_nq", 32'(n_q - q_mark), 32'd2);

    // 4: left and right together cancel
    q_mark = n_q;
    left_req = 1'b1; right_req = 1'b1; cyc(1); left_req = 1'b0; right_req = 1'b0;
    cyc(6);
    chk("lr_nq", 32'(n_q - q_mark), 32'd0);
    chk("lr_x", 32'(bif.piece_x), 32'd2);

    // repeated lefts while one is pending collapse into a single service
    q_mark = n_q;
    push(5'd1, 5'd2); push(5'd0, 5'd2);
    left_req = 1'b1; cyc(1); left_req = 1'b0;
    cyc(1);
    left_req = 1'b1; cyc(2); left_req = 1'b0;
    cyc(8);
    chk("coll_nq", 32'(n_q - q_mark), 32'd2);
    chk("coll_x", 32'(bif.piece_x), 32'd0);

    // 5: tick with hit locks, clear with 2 lines, respawn
    hit_cfg = 1'b1; lock_seen = 1'b0;
    push(5'd0, 5'd3);
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(3);
    chk("lock_valid", 32'(bif.lock_valid), 32'd1);
    chk("lock_y_hold", 32'(bif.piece_y), 32'd2);
    cyc(1);
    chk("lock_pulse_end", 32'(bif.lock_valid), 32'd0);
    chk("clear_req", 32'(bif.clear_req), 32'd1);
    cyc(1);
    chk("clear_req_end", 32'(bif.clear_req), 32'd0);
    hit_cfg = 1'b0;
    cyc(2);
    shape_in = 16'hF000; push(5'd3, 5'd0);
    bif.clear_done = 1'b1; bif.lines_in = 3'd2; cyc(1); bif.clear_done = 1'b0; bif.lines_in = 3'd0;
    chk("lines_total", 32'(lines_total), 32'd2);
    cyc(3);
    chk("respawn_active", 32'(piece_active), 32'd1);
    chk("respawn_shape", 32'(bif.piece_shape), 32'hF000);
    chk("respawn_x", 32'(bif.piece_x), 32'd3);
    chk("respawn_y", 32'(bif.piece_y), 32'd0);

    // 6a: spawn blocked -> game over, further pulses ignored
    reset = 1'b1; cyc(2);
    chk("rst2_lines", 32'(lines_total), 32'd0);
    hit_cfg = 1'b1; start = 1'b1; push(5'd3, 5'd0);
    reset = 1'b0;
    cyc(4);
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_active", 32'(piece_active), 32'd0);
    q_mark = n_q;
    tick = 1'b1; cyc(1); tick = 1'b0; left_req = 1'b1; cyc(1); left_req = 1'b0;
    cyc(6);
    chk("over_nq", 32'(n_q - q_mark), 32'd0);
    chk("over_stay", 32'(game_over), 32'd1);

    // 6b: reset in the middle of a query discards it
    reset = 1'b1; cyc(2);
    chk("rst3_over", 32'(game_over), 32'd0);
    hit_cfg = 1'b0; push(5'd3, 5'd0);
    reset = 1'b0;
    cyc(4);
    start = 1'b0; hit_cfg = 1'b1; lock_seen = 1'b0;
    push(5'd3, 5'd1);
    tick = 1'b1; cyc(1); tick = 1'b0;
    cyc(1);
    chk("midq_valid", 32'(bif.query_valid), 32'd1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    cyc(5);
    chk("midq_nolock", 32'(lock_seen), 32'd0);
    chk("midq_active", 32'(piece_active), 32'd0);
    chk("midq_y", 32'(bif.piece_y), 32'd0);
    chk("midq_qvalid", 32'(bif.query_valid), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
